// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Package : viterbi_pkg
//  Brief   : Shared types and default sizing for the Viterbi ACS scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
package viterbi_pkg;

    // Scheduler FSM states; NORM is only reachable when ACS_NORM_EN is defined
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NORM = 2'd2,
        WRAP = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_STATES = 64;
    localparam int DEF_NUM_UNITS  = 8;
    localparam int DEF_TB_LEN     = 32;

    // Group index width; a single group still needs a one-bit index
    function automatic int grp_width(input int g);
        return (g > 1) ? $clog2(g) : 1;
    endfunction

    localparam int DEF_G  = DEF_NUM_STATES / DEF_NUM_UNITS;
    localparam int DEF_GW = grp_width(DEF_G);
    localparam int DEF_SW = $clog2(DEF_TB_LEN);

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/acs_sched_if.sv
`default_nettype none
// ============================================================================
//  Interface : acs_sched_if
//  Brief     : Symbol handshake plus lane-control bundle of acs_sched.
//              norm_req/norm_en exist only when ACS_NORM_EN is defined.
//              master = symbol source / lane array side, slave = scheduler.
//  Rev       : 1.0  initial release
// ============================================================================
interface acs_sched_if #(
    parameter int GW = 3,
    parameter int SW = 5
);
    logic [1:0]    rx_pair;
    logic          rx_valid;
    logic          rx_ready;
    logic [1:0]    rx_pair_q;
    logic          acs_en;
    logic [GW-1:0] grp_idx;
    logic          pm_rd_bank;
    logic          step_done;
    logic [SW-1:0] step_cnt;
    logic          tb_start;
`ifdef ACS_NORM_EN
    logic          norm_req;
    logic          norm_en;

    modport master (
        output rx_pair, rx_valid, norm_req,
        input  rx_ready, rx_pair_q, acs_en, grp_idx, pm_rd_bank,
               step_done, step_cnt, tb_start, norm_en
    );
    modport slave (
        input  rx_pair, rx_valid, norm_req,
        output rx_ready, rx_pair_q, acs_en, grp_idx, pm_rd_bank,
               step_done, step_cnt, tb_start, norm_en
    );
`else
    modport master (
        output rx_pair, rx_valid,
        input  rx_ready, rx_pair_q, acs_en, grp_idx, pm_rd_bank,
               step_done, step_cnt, tb_start
    );
    modport slave (
        input  rx_pair, rx_valid,
        output rx_ready, rx_pair_q, acs_en, grp_idx, pm_rd_bank,
               step_done, step_cnt, tb_start
    );
`endif
endinterface : acs_sched_if
`default_nettype wire

// File: rtl/acs_step_cnt.sv
`default_nettype none
// ============================================================================
//  Module : acs_step_cnt
//  Brief  : Modulo-TB_LEN trellis step counter with last-value flag.
//  Rev    : 1.0  initial release
// ============================================================================
module acs_step_cnt #(
    parameter int TB_LEN = 32,
    parameter int SW     = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          inc,
    output logic [SW-1:0]      cnt,
    output logic               last
);
    localparam logic [SW-1:0] CNT_LAST = SW'(TB_LEN - 1);

    assign last = (cnt == CNT_LAST);

    // Advance once per completed step, wrapping at TB_LEN-1 (TB_LEN need not be a power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + SW'(1);
        end
    end
endmodule : acs_step_cnt
`default_nettype wire

// File: rtl/acs_sched.sv
`default_nettype none
// ============================================================================
//  Module : acs_sched
//  Brief  : Time-multiplexing scheduler for the Viterbi BMC/ACS lane array.
//           Holds one symbol pair per trellis step, sweeps the lanes over all
//           state groups, ping-pongs path-metric banks and flags traceback.
//           Optional metric normalisation step: define ACS_NORM_EN.
//  Rev    : 1.0  initial release
// ============================================================================
module acs_sched
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int NUM_UNITS  = DEF_NUM_UNITS,
    parameter int TB_LEN     = DEF_TB_LEN
) (
    input  wire logic  clk,
    input  wire logic  rst,
    acs_sched_if.slave bus
);
    localparam int G  = NUM_STATES / NUM_UNITS;
    localparam int GW = grp_width(G);
    localparam int SW = $clog2(TB_LEN);
    localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);

    sched_state_t  state;
    logic [SW-1:0] step_cnt;
    logic          step_last;
`ifdef ACS_NORM_EN
    logic          norm_pending;
`endif

    // Counter advances at the end of the WRAP cycle, so step_last reflects the old value
    acs_step_cnt #(
        .TB_LEN (TB_LEN),
        .SW     (SW)
    ) u_step_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (state == WRAP),
        .cnt  (step_cnt),
        .last (step_last)
    );

    assign bus.step_cnt = step_cnt;

    // Scheduler FSM; every output is a register updated on the transition into its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.rx_ready   <= 1'b1;
            bus.rx_pair_q  <= 2'b00;
            bus.acs_en     <= 1'b0;
            bus.grp_idx    <= '0;
            bus.pm_rd_bank <= 1'b0;
            bus.step_done  <= 1'b0;
            bus.tb_start   <= 1'b0;
`ifdef ACS_NORM_EN
            bus.norm_en    <= 1'b0;
            norm_pending   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        bus.rx_pair_q <= bus.rx_pair;
                        bus.rx_ready  <= 1'b0;
                        bus.acs_en    <= 1'b1;
                        bus.grp_idx   <= '0;
                        state         <= RUN;
                    end
                end
                RUN: begin
`ifdef ACS_NORM_EN
                    if (bus.norm_req) begin
                        norm_pending <= 1'b1;
                    end
`endif
                    if (bus.grp_idx == GRP_LAST) begin
                        bus.acs_en  <= 1'b0;
                        bus.grp_idx <= '0;
`ifdef ACS_NORM_EN
                        // A request in the final group still counts for this step,
                        // otherwise it would leak into the next symbol
                        if (norm_pending || bus.norm_req) begin
                            bus.norm_en <= 1'b1;
                            state       <= NORM;
                        end else begin
                            bus.step_done <= 1'b1;
                            bus.tb_start  <= step_last;
                            state         <= WRAP;
                        end
`else
                        bus.step_done <= 1'b1;
                        bus.tb_start  <= step_last;
                        state         <= WRAP;
`endif
                    end else begin
                        bus.grp_idx <= bus.grp_idx + GW'(1);
                    end
                end
`ifdef ACS_NORM_EN
                NORM: begin
                    bus.norm_en   <= 1'b0;
                    norm_pending  <= 1'b0;
                    bus.step_done <= 1'b1;
                    bus.tb_start  <= step_last;
                    state         <= WRAP;
                end
`endif
                WRAP: begin
                    bus.step_done  <= 1'b0;
                    bus.tb_start   <= 1'b0;
                    bus.pm_rd_bank <= ~bus.pm_rd_bank;
                    bus.rx_ready   <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule : acs_sched
`default_nettype wire

// File: doc/acs_sched.md
# acs_sched

Time-multiplexing scheduler for the Viterbi decoder's branch-metric/add-compare-select datapath. Accepts one received symbol pair per trellis step on a valid/ready handshake and holds it stable. Sweeps the shared BMC/ACS lanes over all state groups of the trellis, ping-pongs the path-metric banks, and tells the traceback unit when a traceback window has filled. Sits between the channel input stage and the bmcXXXXXX/ACS lane array.

## Interface
Parameters:
- NUM_STATES, 64, trellis states; power of two.
- NUM_UNITS, 8, parallel BMC/ACS lanes; power of two, divides NUM_STATES.
- TB_LEN, 32, trellis steps per traceback window; ≥2.
- Derived: G = NUM_STATES/NUM_UNITS; GW = max(1, clog2(G)); SW = clog2(TB_LEN).

Ports:
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- rx_pair, in, 2, received symbol pair (hard bits).
- rx_valid, in, 1, rx_pair valid.
- rx_ready, out, 1, scheduler can accept a symbol.
- rx_pair_q, out, 2, held symbol pair fed to every BMC lane.
- acs_en, out, 1, lanes compute and write this cycle.
- grp_idx, out, GW, state group being processed (lane k handles state grp_idx*NUM_UNITS+k).
- pm_rd_bank, out, 1, path-metric bank read this step; the write bank is ~pm_rd_bank.
- step_done, out, 1, one-cycle pulse when a trellis step completes.
- step_cnt, out, SW, completed steps modulo TB_LEN.
- tb_start, out, 1, one-cycle pulse coincident with the step_done that wraps step_cnt to 0.
- norm_req, in, 1, ACS lane reports a metric above threshold (only with ACS_NORM_EN).
- norm_en, out, 1, lanes subtract the normalisation constant this cycle (only with ACS_NORM_EN).

## Operation
- FSM states: IDLE, RUN, NORM (macro only), WRAP.
- IDLE: rx_ready=1. When rx_valid=1, rx_pair is captured into rx_pair_q, grp_idx is set to 0, and the FSM goes to RUN.
- RUN: acs_en=1 and rx_ready=0; grp_idx increments each cycle.
  - At grp_idx=G-1, the FSM goes to NORM if norm_pending=1, otherwise to WRAP.
  - grp_idx returns to 0 on exit.
- NORM: norm_en=1 and acs_en=0 for one cycle; norm_pending is cleared; then WRAP.
- WRAP: one cycle with acs_en=0.
  - step_done=1.
  - pm_rd_bank toggles at the end of the cycle.
  - step_cnt increments, wrapping TB_LEN-1→0; tb_start=1 when the old value is TB_LEN-1.
  - Next state is IDLE.
- rx_pair_q holds its value from capture until the next capture; it is never modified in RUN, NORM or WRAP.
- norm_pending:
  - set by norm_req sampled high in any RUN cycle;
  - norm_req outside RUN is ignored;
  - set and clear in the same cycle cannot occur, because norm_req is only sampled in RUN.
- G=1: RUN lasts exactly one cycle and grp_idx stays 0.
- rx_valid deasserted in IDLE: the FSM stays in IDLE and all outputs hold.
- Reset:
  - Values: state=IDLE, rx_ready=1, rx_pair_q=0, acs_en=0, grp_idx=0, pm_rd_bank=0, step_done=0, step_cnt=0, tb_start=0, norm_en=0, norm_pending=0.
  - Reset asserted mid-step discards the in-flight symbol and does not toggle pm_rd_bank.

## Timing
- The accept edge is cycle 0. acs_en is high in cycles 1..G with grp_idx=0..G-1.
- step_done and tb_start occur in cycle G+1, or in cycle G+2 when NORM is inserted.
- rx_ready rises in the cycle after step_done.
- Throughput is one symbol per G+2 cycles (G+3 with NORM).
- All outputs are registered or decoded from FSM state only; there is no combinational path from rx_valid or norm_req to any output.

## Configuration
- ACS_NORM_EN defined: the norm_req and norm_en ports, the NORM state and the norm_pending flag exist.
- ACS_NORM_EN undefined:
  - those ports and that state are absent;
  - RUN always proceeds to WRAP;
  - per-symbol latency is fixed at G+2 cycles.

## Structure
- Shared package viterbi_pkg holds:
  - the FSM state enum (IDLE, RUN, NORM, WRAP);
  - the NUM_STATES, NUM_UNITS and TB_LEN defaults;
  - the clog2-derived width constants.
- The single natural sub-module is acs_step_cnt: the modulo-TB_LEN step counter with its wrap pulse, instantiated once.

## Test plan
Defaults NUM_STATES=64, NUM_UNITS=8 (G=8), TB_LEN=4 unless noted.
- Reset: assert rst for 3 cycles → rx_ready=1; every other output 0; after release, no step_done occurs while rx_valid=0.
- Single symbol: rx_pair=2'b10 with rx_valid for 1 cycle → acs_en high for 8 cycles with grp_idx 0..7 and rx_pair_q=2'b10 throughout; step_done in cycle 9; pm_rd_bank=1 afterwards; step_cnt=1.
- Back-to-back: rx_valid held high with 4 symbols → accepts spaced exactly 10 cycles apart; tb_start pulses with the 4th step_done; step_cnt returns to 0; pm_rd_bank is back at 0.
- Normalisation (ACS_NORM_EN): norm_req pulsed during grp_idx=3 → norm_en high in cycle 9 and step_done in cycle 10. The next symbol, sent without norm_req, has no NORM cycle.
- Mid-step reset: rst asserted at grp_idx=5 → all outputs take reset values immediately; pm_rd_bank remains 0; the next accepted symbol starts at grp_idx=0.
- G=1 corner (NUM_UNITS=64): each symbol gives one acs_en cycle with grp_idx=0; step_done in cycle 2.
